// File: rtl/game_sequencer.sv
// Game sequencer: synchronizes v_sync/button, debounces the button per frame and runs the
// IDLE/PLAY/DYING/OVER game FSM. Define HISCORE_EN to keep a best-score register.
`timescale 1ns/1ps

module game_sequencer #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int DYING_FRAMES    = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       v_sync,
  input  logic       button,
  input  logic       collision,
  input  logic [7:0] score,
  output logic       frame_tick,
  output logic       step_en,
  output logic       flap,
  output logic       restart,
  output logic [1:0] state,
  output logic       blink,
  output logic [7:0] hiscore
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] DEB_W   = 4'(DEBOUNCE_FRAMES);
  localparam logic [7:0] DYING_W = 8'(DYING_FRAMES);

  state_t     state_r;
  logic       vs_meta_r, vs_sync_r, vs_prev_r, tick_r;
  logic       bt_meta_r, bt_sync_r, bt_last_r, accepted_r, press_r;
  logic [3:0] stab_r, stab_next_s;
  logic       accept_next_s;
  logic [7:0] dying_r, fcnt_r;
  logic       pending_r, restart_r;
  logic       step_s;

  // input synchronizers and registered v_sync falling-edge pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vs_meta_r <= 1'b0;
      vs_sync_r <= 1'b0;
      vs_prev_r <= 1'b0;
      tick_r    <= 1'b0;
      bt_meta_r <= 1'b1;
      bt_sync_r <= 1'b1;
    end else begin
      vs_meta_r <= v_sync;
      vs_sync_r <= vs_meta_r;
      vs_prev_r <= vs_sync_r;
      tick_r    <= vs_prev_r & ~vs_sync_r;
      bt_meta_r <= button;
      bt_sync_r <= bt_meta_r;
    end
  end

  // per-frame stability count and accepted-level decision
  always_comb begin
    stab_next_s   = stab_r;
    accept_next_s = accepted_r;
    if (tick_r) begin
      if (bt_sync_r == bt_last_r) begin
        if (stab_r != 4'd15) begin
          stab_next_s = stab_r + 4'd1;
        end else begin
          stab_next_s = stab_r;
        end
      end else begin
        stab_next_s = 4'd0;
      end
      if (stab_next_s >= DEB_W) begin
        accept_next_s = bt_sync_r;
      end else begin
        accept_next_s = accepted_r;
      end
    end else begin
      stab_next_s   = stab_r;
      accept_next_s = accepted_r;
    end
  end

  // debounce state, press pulse on accepted 1->0, free-running frame counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stab_r     <= 4'd0;
      bt_last_r  <= 1'b1;
      accepted_r <= 1'b1;
      press_r    <= 1'b0;
      fcnt_r     <= 8'd0;
    end else begin
      stab_r     <= stab_next_s;
      accepted_r <= accept_next_s;
      press_r    <= accepted_r & ~accept_next_s;
      if (tick_r) begin
        bt_last_r <= bt_sync_r;
        fcnt_r    <= fcnt_r + 8'd1;
      end
    end
  end

  // collision wins: it kills the step (and any flap) in its own cycle
  assign step_s = tick_r & (state_r == S_PLAY) & ~collision;

  // game FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      restart_r <= 1'b0;
      pending_r <= 1'b0;
      dying_r   <= 8'd0;
    end else begin
      restart_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (press_r) begin
            state_r   <= S_PLAY;
            restart_r <= 1'b1;
          end
        end
        S_PLAY: begin
          if (collision) begin
            state_r   <= S_DYING;
            dying_r   <= DYING_W;
            pending_r <= 1'b0;
          end else if (step_s) begin
            pending_r <= 1'b0;
          end else if (press_r) begin
            pending_r <= 1'b1;
          end
        end
        S_DYING: begin
          if (tick_r) begin
            dying_r <= dying_r - 8'd1;
            if (dying_r == 8'd1) begin
              state_r <= S_OVER;
            end
          end
        end
        S_OVER: begin
          if (press_r) begin
            state_r   <= S_PLAY;
            restart_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

`ifdef HISCORE_EN
  logic [7:0] hiscore_r;

  // capture the finished game's score if it beats the best so far
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hiscore_r <= 8'd0;
    end else if ((state_r == S_DYING) && tick_r && (dying_r == 8'd1) && (score > hiscore_r)) begin
      hiscore_r <= score;
    end
  end

  assign hiscore = hiscore_r;
`else
  logic unused_score_s;
  assign unused_score_s = ^score;
  assign hiscore        = 8'd0;
`endif

  assign frame_tick = tick_r;
  assign step_en    = step_s;
  assign flap       = step_s & pending_r;
  assign restart    = restart_r;
  assign state      = state_r;
  assign blink      = ((state_r == S_IDLE) || (state_r == S_OVER)) ? fcnt_r[4] : 1'b1;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps

module tb_game_sequencer;

  localparam int D  = 2;
  localparam int DY = 30;
`ifdef HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       v_sync = 1'b0;
  logic       button = 1'b1;
  logic       collision = 1'b0;
  logic [7:0] score = 8'd0;
  logic       frame_tick, step_en, flap, restart, blink;
  logic [1:0] state;
  logic [7:0] hiscore;

  game_sequencer #(.DEBOUNCE_FRAMES(D), .DYING_FRAMES(DY)) dut (
    .clock(clock), .reset(reset), .v_sync(v_sync), .button(button),
    .collision(collision), .score(score), .frame_tick(frame_tick),
    .step_en(step_en), .flap(flap), .restart(restart), .state(state),
    .blink(blink), .hiscore(hiscore)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // v_sync generator: toggles every vs_half clocks
  int vs_half   = 100;
  int gen_falls = 0;
  initial begin
    forever begin
      repeat (vs_half) @(posedge clock);
      #2;
      v_sync = ~v_sync;
      if (!v_sync) gen_falls++;
    end
  end

  // Reference model: raw input history, frame-level debounce and game rules
  logic [2:0] m_vh;
  logic [1:0] m_bh;
  bit  m_tick, m_press, m_restart, m_pending, m_acc, m_last;
  int  m_state, m_dying, m_fcnt, m_hi, m_cnt;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_vh = 3'b000; m_bh = 2'b11;
      m_tick = 0; m_press = 0; m_restart = 0; m_pending = 0; m_acc = 1; m_last = 1;
      m_state = 0; m_dying = 0; m_fcnt = 0; m_hi = 0; m_cnt = 0;
    end else begin
      bit t_old, p_old, bsync, np;
      t_old = m_tick;
      p_old = m_press;
      m_tick = m_vh[2] & ~m_vh[1];
      m_vh = {m_vh[1:0], v_sync};
      bsync = m_bh[1];
      m_bh = {m_bh[0], button};
      np = 0;
      if (t_old) begin
        m_cnt = (bsync == m_last) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
        m_last = bsync;
        if (m_cnt >= D) begin
          np = m_acc && !bsync;
          m_acc = bsync;
        end
        m_fcnt = (m_fcnt + 1) % 256;
      end
      m_press = np;
      m_restart = 0;
      if (m_state == 0 || m_state == 3) begin
        if (p_old) begin m_state = 1; m_restart = 1; end
      end else if (m_state == 1) begin
        if (collision) begin m_state = 2; m_dying = DY; m_pending = 0; end
        else if (t_old) m_pending = 0;
        else if (p_old) m_pending = 1;
      end else if (t_old) begin
        if (m_dying == 1) begin
          m_state = 3;
          if (HI_EN && int'(score) > m_hi) m_hi = int'(score);
        end
        m_dying = m_dying - 1;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clock) begin
    if (reset) begin
      bit exp_step;
      exp_step = m_tick && (m_state == 1) && !collision;
      check("frame_tick", frame_tick, m_tick);
      check("step_en", step_en, exp_step);
      check("flap", flap, exp_step && m_pending);
      check("restart", restart, m_restart);
      check("state", state, m_state);
      check("blink", blink, (m_state == 0 || m_state == 3) ? ((m_fcnt >> 4) & 1) : 1);
      check("hiscore", hiscore, m_hi);
    end
  end

  int n_ticks = 0, n_restarts = 0, n_flaps = 0, n_steps = 0;
  always @(negedge clock) begin
    if (reset) begin
      if (frame_tick) n_ticks++;
      if (restart)    n_restarts++;
      if (flap)       n_flaps++;
      if (step_en)    n_steps++;
    end
  end

  task automatic wait_tick();
    bit got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #2;
      if (m_tick) begin got = 1; break; end
    end
    if (!got) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic press_release();
    wait_tick();
    button = 1'b0;
    wait_ticks(4);
    button = 1'b1;
    wait_ticks(4);
  endtask

  task automatic crash(input logic [7:0] s);
    score = s;
    wait_tick();
    collision = 1'b1;
    #1;
    check("crash_step_en", step_en, 0);
    check("crash_flap", flap, 0);
    @(posedge clock);
    #2;
    collision = 1'b0;
    check("crash_dying", state, 2);
    wait_ticks(DY - 1);
    @(posedge clock);
    #2;
    check("dying_before_last", state, 2);
    wait_ticks(1);
    @(posedge clock);
    #2;
    check("over_after_dying", state, 3);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clock);
    #1;
    check("rst_state", state, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_restart", restart, 0);
    check("rst_step_en", step_en, 0);
    check("rst_hiscore", hiscore, 0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // slow v_sync: one tick per falling edge, nothing else happens
    for (int i = 0; i < 2000 && gen_falls < 3; i++) @(posedge clock);
    check("falls_seen", gen_falls, 3);
    repeat (50) @(posedge clock);
    check("ticks_per_fall", n_ticks, 3);
    check("idle_state", state, 0);
    check("idle_no_step", n_steps, 0);
    vs_half = 10;

    // single-frame glitch must not start a game
    wait_tick();
    button = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    button = 1'b1;
    wait_ticks(4);
    check("glitch_state", state, 0);
    check("glitch_restarts", n_restarts, 0);

    // debounced press starts the game with one restart pulse
    press_release();
    check("start_state", state, 1);
    check("start_restarts", n_restarts, 1);

    // one press -> exactly one flap
    base = n_flaps;
    press_release();
    wait_ticks(3);
    check("one_flap", n_flaps - base, 1);

    // crash while pressing; press during DYING ignored
    button = 1'b0;
    crash(8'd12);
    button = 1'b1;
    check("hiscore_game1", hiscore, HI_EN ? 12 : 0);
    wait_ticks(4);

    // second game, lower score
    press_release();
    check("restart_from_over", state, 1);
    check("restarts_game2", n_restarts, 2);
    crash(8'd7);
    check("hiscore_game2", hiscore, HI_EN ? 12 : 0);
    wait_ticks(4);

    // asynchronous reset in the middle of PLAY
    press_release();
    check("play_before_reset", state, 1);
    base = n_restarts;
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_frame_tick", frame_tick, 0);
    check("arst_step_en", step_en, 0);
    check("arst_flap", flap, 0);
    check("arst_restart", restart, 0);
    check("arst_hiscore", hiscore, 0);
    check("arst_blink", blink, 0);
    #3;
    reset = 1'b1;
    wait_ticks(4);
    check("post_reset_idle", state, 0);
    check("post_reset_no_restart", n_restarts - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_FRAMES, default 2, the number of consecutive frames the synchronized button level must be stable before it is accepted (legal range 1..15).
REQ-002 The block SHALL have parameter DYING_FRAMES, default 30, the number of frames spent in DYING before OVER (legal range 1..255).
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port v_sync, input, 1 bit: VGA vertical sync, high during the sync interval, asynchronous to gameplay.
REQ-006 The block SHALL have port button, input, 1 bit: raw player button, active-low (0 = pressed), asynchronous.
REQ-007 The block SHALL have port collision, input, 1 bit: datapath hit/out-of-bounds flag, sampled only in PLAY.
REQ-008 The block SHALL have port score, input, 8 bits: current datapath score.
REQ-009 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse once per frame.
REQ-010 The block SHALL have port step_en, output, 1 bit: one-cycle datapath advance pulse.
REQ-011 The block SHALL have port flap, output, 1 bit: one-cycle flap command, coincident with step_en.
REQ-012 The block SHALL have port restart, output, 1 bit: one-cycle datapath reinitialise pulse.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-014 The block SHALL have port blink, output, 1 bit: display blink enable.
REQ-015 The block SHALL have port hiscore, output, 8 bits: best score since reset.

Function
REQ-016 The block SHALL pass v_sync and button each through a 2-flop synchronizer before any other use.
REQ-017 frame_tick SHALL pulse for exactly one cycle, one cycle after the synchronized v_sync falls from 1 to 0, and SHALL not pulse while v_sync stays constant.
REQ-018 Debounce: on each frame_tick, a 4-bit stability counter SHALL increment if the synchronized button equals the last sample and otherwise clear; the accepted level SHALL update when the count reaches DEBOUNCE_FRAMES.
REQ-019 A press event SHALL be a one-cycle internal pulse when the accepted level goes from 1 to 0; release SHALL generate no event.
REQ-020 From IDLE, a press event SHALL move the FSM to PLAY and assert restart in the same cycle as the transition.
REQ-021 In PLAY, step_en SHALL equal frame_tick.
REQ-022 In PLAY, a press event SHALL set a pending_flap flag; on the next step_en, flap SHALL assert with it and pending_flap SHALL clear.
REQ-023 In PLAY, collision=1 SHALL move the FSM to DYING, load the dying counter with DYING_FRAMES, clear pending_flap, and suppress step_en and flap in that cycle.
REQ-024 collision SHALL have priority over a simultaneous press event and a simultaneous frame_tick.
REQ-025 In DYING, the dying counter SHALL decrement on each frame_tick; on a frame_tick with counter=1, the FSM SHALL move to OVER. Press events SHALL be ignored.
REQ-026 From OVER, a press event SHALL move the FSM to PLAY with restart asserted.
REQ-027 Outside PLAY, step_en and flap SHALL be 0.
REQ-028 A free-running 8-bit frame counter SHALL increment on every frame_tick and wrap from 255 to 0.
REQ-029 blink SHALL equal frame counter bit 4 in IDLE and OVER, and SHALL be 1 in PLAY and DYING.

Reset
REQ-030 While reset=0, all flops SHALL clear asynchronously: state=IDLE, frame_tick=step_en=flap=restart=0, hiscore=0, all counters=0, pending_flap=0, and the accepted button level=1 (released).
REQ-031 Reset deassertion mid-game SHALL resume in IDLE; no restart pulse SHALL be emitted until a press event occurs.

Configuration
REQ-032 With macro HISCORE_EN defined, hiscore SHALL load score on the DYING->OVER transition if score > hiscore (unsigned), and SHALL hold otherwise.
REQ-033 Without HISCORE_EN, hiscore SHALL be tied to 0 and no hiscore register SHALL be synthesized.

Verification
REQ-034 v_sync toggling every 100 clocks -> exactly one frame_tick per falling edge; state=0; step_en=0.
REQ-035 In IDLE, button held 0 for 3 frames (DEBOUNCE_FRAMES=2) -> one restart pulse, state=1; a 1-frame glitch -> no transition.
REQ-036 In PLAY, one debounced press -> flap=1 together with the next step_en only; no flap on later ticks.
REQ-037 In PLAY, collision=1 in the same cycle as frame_tick and a press -> state=2, step_en=0, flap=0; after 30 frame_ticks -> state=3.
REQ-038 With HISCORE_EN and score=12, then 7 on the next game -> hiscore=12 after each OVER; without HISCORE_EN -> hiscore=0.
REQ-039 reset pulled low mid-PLAY, asynchronously to clock -> all outputs cleared immediately and state=0.
